slf_axi_gpio: RTL and testbench
===============================

// Module: slf_axi_gpio
// PURPOSE
//  AXI4-Lite slave GPIO block replacing fixed LED/PB/DIP wiring in SLF designs.
//  Provides parametrised output and input widths, input synchronisers and per-pin edge interrupts.
//  Drives a single level INTERRUPT line to the PS.
//  Sits directly on the PS GP slave port, or on the axi4_slave_slot in simulation.
// PARAMETERS
//  addr_width  24  AXI address width; only addr[4:2] are decoded
//  n_out       8   output pins (1..32)
//  n_in        8   input pins (1..32)
//  db_cycles   16  debounce stable-count threshold (used only with SLF_GPIO_DEBOUNCE_EN)
// PORTS
//  AXI_ACLK       in   1           single clock for the whole block
//  AXI_ARESET     in   1           synchronous, active-high reset
//  AXI_S_AW*      AWVALID in/AWREADY out/AWADDR in addr_width/AWPROT in 3 (ignored)
//  AXI_S_W*       WVALID in/WREADY out/WDATA in 32/WSTRB in 4
//  AXI_S_B*       BVALID out/BREADY in/BRESP out 2
//  AXI_S_AR*      ARVALID in/ARREADY out/ARADDR in addr_width/ARPROT in 3 (ignored)
//  AXI_S_R*       RVALID out/RREADY in/RDATA out 32/RRESP out 2
//  INTERRUPT      out  1           level IRQ = |(IRQ_STAT & IRQ_EN), registered
//  GPIO_OUT       out  n_out       OUT register contents
//  GPIO_IN        in   n_in        asynchronous pins (buttons, switches)
// BEHAVIOUR
//  Reset (sync, high): all READY=1 except B/R path; BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0;
//   OUT=0, IRQ_EN=0, IRQ_STAT=0, EDGE=0, INTERRUPT=0, synchroniser flops=0.
//   Reset mid-transaction drops any pending BVALID/RVALID; no response is issued.
//  Register map (byte offset, addr[4:2]); bits above n_in/n_out read 0:
//   0x00 OUT       RW  GPIO_OUT; WSTRB lanes honoured
//   0x04 IN        RO  synchronised (optionally debounced) inputs
//   0x08 IRQ_EN    RW  per-input interrupt enable
//   0x0C IRQ_STAT  R/W1C  latched edge events
//   0x10 EDGE      RW  per-input polarity: 0=rising, 1=falling
//   0x14 ID        RO  {8'h47, 8'(n_in), 8'(n_out), 8'h01}
//   0x18,0x1C      RO  read 0, writes ignored; all responses OKAY (2'b00)
//  Write path: AW and W accepted independently and latched.
//   AWREADY=0 while AW is held or BVALID=1; WREADY likewise for W.
//   Register update occurs in the cycle after both are held; BVALID=1 in that same cycle.
//   Fastest case: AW+W together at cycle N, BVALID at N+1.
//   BVALID holds until BREADY; AW/W readiness returns the cycle after B handshake.
//  Read path: ARREADY=!RVALID. AR handshake at N -> RVALID, RDATA at N+1.
//   RDATA is stable until RREADY; the next AR is accepted the cycle after the R handshake.
//  Read and write proceed concurrently; a same-cycle read of a register being written returns the old value.
//  Inputs: 2-flop synchroniser, then edge detect against the previous synchronised value.
//   A qualifying edge sets IRQ_STAT[i] regardless of IRQ_EN.
//  Simultaneous hardware set and W1C clear of the same bit: set wins (bit stays 1).
//  INTERRUPT updates one cycle after IRQ_STAT/IRQ_EN changes.
//  Latency pin->IRQ_STAT: 3 cycles (2 sync + 1 edge), without debounce.
// CONFIGURATION
//  SLF_GPIO_DEBOUNCE_EN defined:
//   - per-input counter of $clog2(db_cycles+1) bits after the synchroniser;
//     it resets when the raw sync value differs from the debounced value.
//   - the debounced value updates when the counter reaches db_cycles.
//   - edge detect and the IN register use the debounced value.
//   - latency becomes 3+db_cycles cycles.
//   - glitches shorter than db_cycles cycles produce no event.
//  Undefined: no counters; edge detect and IN use the synchroniser output directly.
// TESTING
//  1. Reset, read 0x14 -> RDATA=32'h47080801, RRESP=0; read 0x00 -> 0; INTERRUPT=0.
//  2. AW=0x00,W=0xA5,WSTRB=4'hF same cycle -> BVALID next cycle, GPIO_OUT=8'hA5; WSTRB=4'h0 write 0xFF -> OUT unchanged.
//  3. AW first, W 3 cycles later, BREADY low 2 cycles -> single B response; AWREADY low until B handshake.
//  4. IRQ_EN=0x01, EDGE=0, GPIO_IN[0] 0->1 -> IRQ_STAT=0x01 after 3 cycles, INTERRUPT=1 one cycle later;
//     W1C 0x01 -> INTERRUPT=0.
//  5. W1C of bit 0 in the same cycle as a new rising edge on GPIO_IN[0] -> IRQ_STAT[0] stays 1.
//  6. With SLF_GPIO_DEBOUNCE_EN and db_cycles=16: 10-cycle pulse -> no event; 20-cycle pulse -> IRQ_STAT set.
//     Assert AXI_ARESET while RVALID=1 -> RVALID=0 next cycle.

Source files
------------

// File: rtl/slf_axi_gpio.sv
// AXI4-Lite GPIO slave: output register, synchronised inputs and per-pin edge interrupts.
// Optional input debounce is enabled by defining SLF_GPIO_DEBOUNCE_EN.
module slf_axi_gpio #(
  parameter int unsigned addr_width = 24,
  parameter int unsigned n_out      = 8,
  parameter int unsigned n_in       = 8,
  parameter int unsigned db_cycles  = 16
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESET,
  input  logic                  AXI_S_AWVALID,
  output logic                  AXI_S_AWREADY,
  input  logic [addr_width-1:0] AXI_S_AWADDR,
  input  logic [2:0]            AXI_S_AWPROT,
  input  logic                  AXI_S_WVALID,
  output logic                  AXI_S_WREADY,
  input  logic [31:0]           AXI_S_WDATA,
  input  logic [3:0]            AXI_S_WSTRB,
  output logic                  AXI_S_BVALID,
  input  logic                  AXI_S_BREADY,
  output logic [1:0]            AXI_S_BRESP,
  input  logic                  AXI_S_ARVALID,
  output logic                  AXI_S_ARREADY,
  input  logic [addr_width-1:0] AXI_S_ARADDR,
  input  logic [2:0]            AXI_S_ARPROT,
  output logic                  AXI_S_RVALID,
  input  logic                  AXI_S_RREADY,
  output logic [31:0]           AXI_S_RDATA,
  output logic [1:0]            AXI_S_RRESP,
  output logic                  INTERRUPT,
  output logic [n_out-1:0]      GPIO_OUT,
  input  logic [n_in-1:0]       GPIO_IN
);

  logic            aw_held, w_held, bvalid, rvalid, irq;
  logic [2:0]      aw_sel;
  logic [31:0]     w_data, rdata;
  logic [3:0]      w_strb;
  logic [n_out-1:0] out_reg;
  logic [n_in-1:0]  en_reg, stat_reg, edge_pol;
  logic [n_in-1:0]  sync1, sync2, in_val, in_prev, events;

  logic            aw_hs, w_hs, ar_hs, wr_fire;
  logic [2:0]      wr_sel;
  logic [31:0]     wr_data, lane_mask, wr_bits, rd_word;
  logic [3:0]      wr_strb;
  logic [n_out-1:0] out_next;
  logic [n_in-1:0]  en_next, edge_next, w1c_mask;

  assign AXI_S_AWREADY = !aw_held && !bvalid;
  assign AXI_S_WREADY  = !w_held && !bvalid;
  assign AXI_S_ARREADY = !rvalid;
  assign AXI_S_BVALID  = bvalid;
  assign AXI_S_BRESP   = '0;
  assign AXI_S_RVALID  = rvalid;
  assign AXI_S_RDATA   = rdata;
  assign AXI_S_RRESP   = '0;
  assign INTERRUPT     = irq;
  assign GPIO_OUT      = out_reg;

  assign aw_hs = AXI_S_AWVALID && AXI_S_AWREADY;
  assign w_hs  = AXI_S_WVALID && AXI_S_WREADY;
  assign ar_hs = AXI_S_ARVALID && AXI_S_ARREADY;

  // A beat arriving this cycle combines with a previously held one, so the
  // fastest write completes on the same edge that accepts AW and W.
  assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);

  always_comb begin
    wr_sel    = aw_hs ? AXI_S_AWADDR[4:2] : aw_sel;
    wr_data   = w_hs ? AXI_S_WDATA : w_data;
    wr_strb   = w_hs ? AXI_S_WSTRB : w_strb;
    lane_mask = '0;
    for (int unsigned b = 0; b < 4; b++) lane_mask[8*b +: 8] = {8{wr_strb[b]}};
    wr_bits   = wr_data & lane_mask;
    out_next  = (out_reg & ~lane_mask[n_out-1:0]) | wr_bits[n_out-1:0];
    en_next   = (en_reg & ~lane_mask[n_in-1:0]) | wr_bits[n_in-1:0];
    edge_next = (edge_pol & ~lane_mask[n_in-1:0]) | wr_bits[n_in-1:0];
    w1c_mask  = (wr_fire && wr_sel == 3'd3) ? wr_bits[n_in-1:0] : '0;
  end

  always_comb begin
    rd_word = '0;
    case (AXI_S_ARADDR[4:2])
      3'd0:    rd_word = 32'(out_reg);
      3'd1:    rd_word = 32'(in_val);
      3'd2:    rd_word = 32'(en_reg);
      3'd3:    rd_word = 32'(stat_reg);
      3'd4:    rd_word = 32'(edge_pol);
      3'd5:    rd_word = {8'h47, 8'(n_in), 8'(n_out), 8'h01};
      default: rd_word = '0;
    endcase
  end

  assign events = (~edge_pol & ~in_prev & in_val) | (edge_pol & in_prev & ~in_val);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      out_reg  <= '0;
      en_reg   <= '0;
      stat_reg <= '0;
      edge_pol <= '0;
      irq      <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      in_prev  <= '0;
    end else begin
      if (bvalid && AXI_S_BREADY) bvalid <= 1'b0;
      if (wr_fire) begin
        bvalid  <= 1'b1;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        case (wr_sel)
          3'd0:    out_reg  <= out_next;
          3'd2:    en_reg   <= en_next;
          3'd4:    edge_pol <= edge_next;
          default: ;
        endcase
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_sel  <= AXI_S_AWADDR[4:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= AXI_S_WDATA;
          w_strb <= AXI_S_WSTRB;
        end
      end

      if (rvalid && AXI_S_RREADY) rvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end

      // Hardware set is OR-ed in after the clear so a coincident event wins.
      stat_reg <= (stat_reg & ~w1c_mask) | events;
      irq      <= |(stat_reg & en_reg);
      sync1    <= GPIO_IN;
      sync2    <= sync1;
      in_prev  <= in_val;
    end
  end

`ifdef SLF_GPIO_DEBOUNCE_EN
  localparam int unsigned cw = $clog2(db_cycles + 1);
  logic [cw-1:0]   db_cnt [n_in];
  logic [n_in-1:0] db_val;

  // Counter runs only while the synchronised pin disagrees with the debounced
  // value; any return to agreement restarts it, so short glitches are dropped.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      db_val <= '0;
      for (int unsigned i = 0; i < n_in; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < n_in; i++) begin
        if (sync2[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + 1'b1 == cw'(db_cycles)) begin
          db_val[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign in_val = db_val;

  logic unused_bits;
  assign unused_bits = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_AWADDR[addr_width-1:5],
                         AXI_S_AWADDR[1:0], AXI_S_ARADDR[addr_width-1:5],
                         AXI_S_ARADDR[1:0], wr_bits};
`else
  assign in_val = sync2;

  logic unused_bits;
  assign unused_bits = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_AWADDR[addr_width-1:5],
                         AXI_S_AWADDR[1:0], AXI_S_ARADDR[addr_width-1:5],
                         AXI_S_ARADDR[1:0], wr_bits, 32'(db_cycles)};
`endif

endmodule

// File: tb/tb_slf_axi_gpio.sv
// Directed self-checking bench for slf_axi_gpio (default 8-in/8-out configuration).
module tb_slf_axi_gpio;

`ifdef SLF_GPIO_DEBOUNCE_EN
  localparam int unsigned LAT = 19;
`else
  localparam int unsigned LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [23:0] awaddr, araddr;
  logic [31:0] wdata, rdata, rd;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  gpio_out, gpio_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  slf_axi_gpio #(.addr_width(24), .n_out(8), .n_in(8), .db_cycles(16)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .AXI_S_AWVALID(awvalid), .AXI_S_AWREADY(awready), .AXI_S_AWADDR(awaddr), .AXI_S_AWPROT(3'b000),
    .AXI_S_WVALID(wvalid), .AXI_S_WREADY(wready), .AXI_S_WDATA(wdata), .AXI_S_WSTRB(wstrb),
    .AXI_S_BVALID(bvalid), .AXI_S_BREADY(bready), .AXI_S_BRESP(bresp),
    .AXI_S_ARVALID(arvalid), .AXI_S_ARREADY(arready), .AXI_S_ARADDR(araddr), .AXI_S_ARPROT(3'b000),
    .AXI_S_RVALID(rvalid), .AXI_S_RREADY(rready), .AXI_S_RDATA(rdata), .AXI_S_RRESP(rresp),
    .INTERRUPT(irq), .GPIO_OUT(gpio_out), .GPIO_IN(gpio_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic axi_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int unsigned n = 0;
    awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [23:0] addr, output logic [31:0] data);
    int unsigned n = 0;
    arvalid = 1'b1; araddr = addr;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rresp", 32'(rresp), 32'd0);
    data = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; gpio_in = '0;
    ticks(3);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    rst = 1'b0;

    axi_read(24'h14, rd); chk("id", rd, 32'h47080801);
    axi_read(24'h00, rd); chk("out_reset", rd, 32'd0);
    chk("irq_idle", 32'(irq), 32'd0);

    // Fastest write: AW and W together, BVALID the next cycle.
    awvalid = 1'b1; awaddr = 24'h00; wvalid = 1'b1; wdata = 32'hA5; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("fast_bvalid", 32'(bvalid), 32'd1);
    chk("fast_gpio_out", 32'(gpio_out), 32'hA5);
    chk("fast_awready_busy", 32'(awready), 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("fast_awready_back", 32'(awready), 32'd1);
    axi_write(24'h00, 32'hFF, 4'h0); chk("strb0_out", 32'(gpio_out), 32'hA5);
    axi_write(24'h00, 32'h0000_FF3C, 4'h1); chk("strb1_out", 32'(gpio_out), 32'h3C);
    axi_write(24'h18, 32'hFFFF_FFFF, 4'hF);
    axi_read(24'h18, rd); chk("reserved_18", rd, 32'd0);

    // Same-cycle read of the register being written returns the old value.
    awvalid = 1'b1; awaddr = 24'h00; wvalid = 1'b1; wdata = 32'h5A; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 24'h00;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_rvalid", 32'(rvalid), 32'd1);
    chk("rw_old_rdata", rdata, 32'h3C);
    chk("rw_new_out", 32'(gpio_out), 32'h5A);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;

    // AW first, W three cycles later, BREADY held low for two cycles.
    awvalid = 1'b1; awaddr = 24'h10;
    tick();
    awvalid = 1'b0;
    chk("split_awready_held", 32'(awready), 32'd0);
    chk("split_no_b_early", 32'(bvalid), 32'd0);
    ticks(2);
    chk("split_no_b_wait", 32'(bvalid), 32'd0);
    chk("split_wready", 32'(wready), 32'd1);
    wvalid = 1'b1; wdata = 32'h02; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    chk("split_bvalid", 32'(bvalid), 32'd1);
    tick(); chk("split_bhold1", 32'(bvalid), 32'd1);
    tick(); chk("split_bhold2", 32'(bvalid), 32'd1);
    chk("split_awready_during_b", 32'(awready), 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("split_bdone", 32'(bvalid), 32'd0);
    chk("split_awready_after", 32'(awready), 32'd1);
    ticks(2);
    chk("split_single_b", 32'(bvalid), 32'd0);
    axi_read(24'h10, rd); chk("edge_readback", rd, 32'h02);

    // Edge events: bit0 rising (enabled), bit1 rising (falling polarity), bit2 rising (not enabled).
    axi_write(24'h08, 32'h01, 4'hF);
    gpio_in = 8'h07;
    ticks(LAT);
    chk("irq_lat_before", 32'(irq), 32'd0);
    tick();
    chk("irq_lat_after", 32'(irq), 32'd1);
    axi_read(24'h0C, rd); chk("stat_rise", rd, 32'h05);
    axi_read(24'h04, rd); chk("in_reg", rd, 32'h07);
    axi_write(24'h0C, 32'h01, 4'hF);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    axi_read(24'h0C, rd); chk("stat_w1c", rd, 32'h04);
    gpio_in = 8'h05;
    ticks(LAT + 3);
    axi_read(24'h0C, rd); chk("stat_fall", rd, 32'h06);
    axi_write(24'h0C, 32'hFF, 4'hF);
    gpio_in = 8'h00;
    ticks(LAT + 3);
    axi_read(24'h0C, rd); chk("stat_clear", rd, 32'h00);

    // W1C lands on the same edge as a new rising event on bit0: set wins.
    gpio_in = 8'h01;
    ticks(LAT - 1);
    awvalid = 1'b1; awaddr = 24'h0C; wvalid = 1'b1; wdata = 32'h01; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("collide_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1; tick(); bready = 1'b0;
    axi_read(24'h0C, rd); chk("collide_stat", rd, 32'h01);
    chk("collide_irq", 32'(irq), 32'd1);

`ifdef SLF_GPIO_DEBOUNCE_EN
    axi_write(24'h0C, 32'hFF, 4'hF);
    gpio_in = 8'h08; ticks(10); gpio_in = 8'h00;
    ticks(LAT + 5);
    axi_read(24'h0C, rd); chk("db_glitch", rd, 32'h00);
    gpio_in = 8'h08; ticks(20); gpio_in = 8'h00;
    ticks(2 * LAT);
    axi_read(24'h0C, rd); chk("db_pulse", rd, 32'h08);
`endif

    // Reset while a read response is pending drops it.
    gpio_in = 8'h00;
    arvalid = 1'b1; araddr = 24'h14;
    tick();
    arvalid = 1'b0;
    chk("pend_rvalid", 32'(rvalid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_drop_rvalid", 32'(rvalid), 32'd0);
    chk("rst_drop_irq", 32'(irq), 32'd0);
    chk("rst_drop_out", 32'(gpio_out), 32'd0);
    rst = 1'b0;
    tick();
    axi_read(24'h00, rd); chk("post_rst_out", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
